// File: rtl/iter_addsub.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock, delivering Sum and
// status flags after WIDTH/CHUNK cycles behind a valid/ready handshake.
module iter_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  input  logic             Cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero,
  output logic             Neg
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, acc_q, acc_d, sum_q, sum_d;
  logic             carry_q, carry_d, sub_q, sub_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d;

  logic [CHUNK-1:0] a_chunk, b_chunk, part;
  logic [CHUNK:0]   chunk_sum;
  logic             c_out, c_msb;
  int               idx;

  // One chunk of the ripple chain; subtraction arrives pre-inverted in opb_q.
  always_comb begin
    idx       = int'(cnt_q) * CHUNK;
    a_chunk   = opa_q[idx +: CHUNK];
    b_chunk   = opb_q[idx +: CHUNK];
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK+1)'(carry_q);
    part      = chunk_sum[CHUNK-1:0];
    c_out     = chunk_sum[CHUNK];
    // Carry into the MSB is recovered from the MSB's own sum bit.
    c_msb     = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ part[CHUNK-1];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          opa_d   = A;
          opb_d   = sub ? ~B : B;
          carry_d = Cin ^ sub;
          sub_d   = sub;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d[idx +: CHUNK] = part;
        carry_d = c_out;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          sum_d   = acc_d;
          cout_d  = c_out ^ sub_q;
          ovf_d   = c_msb ^ c_out;
          zero_d  = (acc_d == '0);
          neg_d   = acc_d[WIDTH-1];
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign Sum         = sum_q;
  assign Cout        = cout_q;
  assign Ovf         = ovf_q;
  assign Zero        = zero_q;
  assign Neg         = neg_q;

endmodule

// File: tb/tb_iter_addsub.sv
// Bench for iter_addsub: a 16/4 instance and an 8/8 instance checked every cycle
// against an arithmetic reference model, plus literal cases pinning the model.
module tb_iter_addsub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int W[2]  = '{16, 8};
  int NC[2] = '{4, 1};

  logic [15:0] a_v[2];
  logic [15:0] b_v[2];
  logic        sub_v[2];
  logic        cin_v[2];
  logic [1:0]  sv;
  logic [1:0]  rr;

  logic        sr0, rv0, co0, ov0, ze0, ne0;
  logic        sr1, rv1, co1, ov1, ze1, ne1;
  logic [15:0] sum0;
  logic [7:0]  sum1;
  logic [1:0]  sr_v, rv_v;
  assign sr_v = {sr1, sr0};
  assign rv_v = {rv1, rv0};

  int checks = 0;
  int errors = 0;

  iter_addsub #(.WIDTH(16), .CHUNK(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv[0]), .start_ready(sr0),
    .A(a_v[0]), .B(b_v[0]), .sub(sub_v[0]), .Cin(cin_v[0]),
    .res_valid(rv0), .res_ready(rr[0]), .Sum(sum0),
    .Cout(co0), .Ovf(ov0), .Zero(ze0), .Neg(ne0));

  iter_addsub #(.WIDTH(8), .CHUNK(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv[1]), .start_ready(sr1),
    .A(a_v[1][7:0]), .B(b_v[1][7:0]), .sub(sub_v[1]), .Cin(cin_v[1]),
    .res_valid(rv1), .res_ready(rr[1]), .Sum(sum1),
    .Cout(co1), .Ovf(ov1), .Zero(ze1), .Neg(ne1));

  // Result word layout: {Cout, Ovf, Zero, Neg, Sum[15:0]}
  function automatic logic [19:0] ref_op(int w, logic [15:0] a, logic [15:0] b,
                                         logic s, logic c);
    longint m, hi, lo, ua, ub, sa, sb, full, sres, lc;
    logic co, ov;
    logic [15:0] r;
    m  = (longint'(1) << w) - 1;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -hi - 1;
    ua = longint'(a) & m;
    ub = longint'(b) & m;
    lc = c ? 1 : 0;
    sa = (ua > hi) ? ua - m - 1 : ua;
    sb = (ub > hi) ? ub - m - 1 : ub;
    if (!s) begin
      full = ua + ub + lc;
      co   = (full > m);
      sres = sa + sb + lc;
    end else begin
      full = ua - ub - lc;
      co   = (ua < ub + lc);
      sres = sa - sb - lc;
    end
    r  = 16'(full & m);
    ov = (sres > hi) || (sres < lo);
    return {co, ov, (r == 16'h0), r[w-1], r};
  endfunction

  function automatic logic [19:0] dut_out(int id);
    if (id == 0) return {co0, ov0, ze0, ne0, sum0};
    return {co1, ov1, ze1, ne1, 8'h00, sum1};
  endfunction

  // Reference model: per-instance operation in flight and the values the outputs must show.
  bit          inflight[2];
  int          age[2];
  logic [19:0] expv[2];
  logic [19:0] shown[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        inflight[i] <= 1'b0;
        age[i]      <= 0;
        shown[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!inflight[i]) begin
          if (sv[i]) begin
            inflight[i] <= 1'b1;
            age[i]      <= 0;
            expv[i]     <= ref_op(W[i], a_v[i], b_v[i], sub_v[i], cin_v[i]);
          end
        end else if (age[i] == NC[i]) begin
          if (rr[i]) inflight[i] <= 1'b0;
        end else begin
          age[i] <= age[i] + 1;
          if (age[i] + 1 == NC[i]) shown[i] <= expv[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic erv, esr;
      logic [19:0] got;
      erv = inflight[i] && (age[i] == NC[i]);
      esr = !inflight[i];
      got = dut_out(i);
      checks++;
      if (got !== shown[i] || rv_v[i] !== erv || sr_v[i] !== esr) begin
        errors++;
        $display("FAIL cycle dut%0d: got out=%h rv=%b sr=%b, want out=%h rv=%b sr=%b",
                 i, got, rv_v[i], sr_v[i], shown[i], erv, esr);
      end
    end
  end

  task automatic run_op(input int id, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic c, input int hold,
                        input bit lit, input logic [19:0] want);
    int n;
    a_v[id] = a; b_v[id] = b; sub_v[id] = s; cin_v[id] = c;
    sv[id] = 1'b1;
    @(posedge clk); #1;
    sv[id] = 1'b0;
    a_v[id] = 16'($urandom); b_v[id] = 16'($urandom);
    sub_v[id] = 1'($urandom); cin_v[id] = 1'($urandom);
    n = 0;
    while (!rv_v[id] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rv_v[id]) begin
      checks++; errors++;
      $display("FAIL timeout dut%0d: res_valid=%b after %0d cycles, want 1", id, rv_v[id], n);
      return;
    end
    if (lit) begin
      checks++;
      if (n != NC[id]) begin
        errors++;
        $display("FAIL latency dut%0d: got %0d, want %0d", id, n, NC[id]);
      end
      checks++;
      if (dut_out(id) !== want) begin
        errors++;
        $display("FAIL literal dut%0d: got %h, want %h", id, dut_out(id), want);
      end
      checks++;
      if (ref_op(W[id], a, b, s, c) !== want) begin
        errors++;
        $display("FAIL model dut%0d: got %h, want %h", id, ref_op(W[id], a, b, s, c), want);
      end
    end
    repeat (hold) begin
      sv[id] = 1'($urandom);
      a_v[id] = 16'($urandom);
      @(posedge clk); #1;
    end
    sv[id] = 1'b0;
    rr[id] = 1'b1;
    @(posedge clk); #1;
    rr[id] = 1'b0;
    if (lit) begin
      checks++;
      if (rv_v[id] !== 1'b0 || sr_v[id] !== 1'b1) begin
        errors++;
        $display("FAIL handshake dut%0d: rv=%b sr=%b, want rv=0 sr=1", id, rv_v[id], sr_v[id]);
      end
    end
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    sv = '0; rr = '0;
    for (int i = 0; i < 2; i++) begin
      a_v[i] = '0; b_v[i] = '0; sub_v[i] = 1'b0; cin_v[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    checks++;
    if (sr0 !== 1'b1 || rv0 !== 1'b0 || dut_out(0) !== 20'h0) begin
      errors++;
      $display("FAIL reset_state: sr=%b rv=%b out=%h, want sr=1 rv=0 out=0", sr0, rv0, dut_out(0));
    end

    run_op(0, 16'h0001, 16'h0002, 1'b0, 1'b0, 5, 1'b1, {4'b0000, 16'h0003});
    run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b1, {4'b1010, 16'h0000});
    run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1, 1'b1, {4'b0101, 16'h8000});
    run_op(0, 16'h0004, 16'h0003, 1'b1, 1'b0, 2, 1'b1, {4'b0000, 16'h0001});
    run_op(0, 16'h0003, 16'h0004, 1'b1, 1'b0, 0, 1'b1, {4'b1001, 16'hFFFF});
    run_op(0, 16'h0004, 16'h0003, 1'b1, 1'b1, 3, 1'b1, {4'b0010, 16'h0000});
    run_op(0, 16'h8000, 16'h0001, 1'b1, 1'b0, 0, 1'b1, {4'b0100, 16'h7FFF});
    run_op(1, 16'h0001, 16'h0002, 1'b0, 1'b0, 2, 1'b1, {4'b0000, 16'h0003});
    run_op(1, 16'h007F, 16'h0001, 1'b0, 1'b0, 0, 1'b1, {4'b0101, 16'h0080});

    // Abort an operation two cycles into BUSY.
    a_v[0] = 16'h1234; b_v[0] = 16'h1111; sub_v[0] = 1'b0; cin_v[0] = 1'b0;
    sv[0] = 1'b1;
    @(posedge clk); #1;
    sv[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (sr0 !== 1'b1 || rv0 !== 1'b0 || dut_out(0) !== 20'h0) begin
      errors++;
      $display("FAIL abort_reset: sr=%b rv=%b out=%h, want sr=1 rv=0 out=0", sr0, rv0, dut_out(0));
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (sr0 !== 1'b1) begin
      errors++;
      $display("FAIL abort_ready: sr=%b, want 1", sr0);
    end
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (rv0 !== 1'b0) begin
      errors++;
      $display("FAIL abort_novalid: rv=%b, want 0", rv0);
    end

    for (int k = 0; k < 160; k++) begin
      int id;
      id = int'($urandom_range(0, 1));
      run_op(id, pick(), pick(), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), 1'b0, 20'h0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
